mul_share_sequencer: RTL and testbench

Sequencer and round-robin arbiter that shares one iterative shift-add multiplier between two requesters, for example the MiniAlu execute stage and a second ALU or DMA-style client. It accepts one operand pair at a time through a valid/ready handshake and runs a fixed-latency radix-2 multiply over DATA_WIDTH cycles. It returns the truncated product with a one-cycle done pulse to the granted requester. This replaces per-requester combinational multipliers with a single small multi-cycle unit.

---
 rtl/mul_share_sequencer_pkg.sv | 18 +
 rtl/mul_share_sequencer_core.sv | 63 ++++++
 rtl/mul_share_sequencer.sv | 107 ++++++++++
 tb/tb_mul_share_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_sequencer_pkg.sv
// Shared definitions for the shared shift-add multiplier sequencer.
// Contents:
//   MULSEQ_DEFAULT_WIDTH : default operand/result width and iteration count.
//   MULSEQ_IDLE/RUN/DONE : sequencer state encodings.
//   mulseq_cnt_width()   : width of the iteration counter for a given width.
package mul_share_sequencer_pkg;

  localparam int unsigned MULSEQ_DEFAULT_WIDTH = 16;

  localparam logic [1:0] MULSEQ_IDLE = 2'd0;
  localparam logic [1:0] MULSEQ_RUN  = 2'd1;
  localparam logic [1:0] MULSEQ_DONE = 2'd2;

  function automatic int unsigned mulseq_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_share_sequencer_core.sv
// Iterative radix-2 shift-add multiplier datapath (one bit per cycle).
// Ports:
//   Clock, Reset : rising-edge clock, synchronous active-high reset.
//   iStart       : load operands, clear accumulator and counter.
//   iA, iB       : multiplicand and multiplier (sampled on iStart only).
//   oProduct     : accumulator value after the current iteration.
//   oLast        : high during the final iteration of an operation.
module mul_shift_add_core
  import mul_share_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULSEQ_DEFAULT_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  output logic [DATA_WIDTH-1:0] oProduct,
  output logic                  oLast
);

  localparam int unsigned CW = mulseq_cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [CW-1:0]         count;
  logic                  active;

  // Product is presented including the current iteration's add so the
  // owner can capture it on the same edge that finishes the last iteration.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    oProduct = acc_next;
    oLast    = active && (count == CW'(DATA_WIDTH - 1));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (iStart) begin
      mcand  <= iA;
      mplier <= iB;
      acc    <= '0;
      count  <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (oLast) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_share_sequencer.sv
// Two-requester round-robin front end for one shared iterative multiplier.
// Ports:
//   Clock, Reset        : rising-edge clock, synchronous active-high reset.
//   iValid0/iA0/iB0     : requester 0 operand pair and valid.
//   oReady0, oDone0     : requester 0 accept strobe and one-cycle completion.
//   iValid1/iA1/iB1     : requester 1 operand pair and valid.
//   oReady1, oDone1     : requester 1 accept strobe and one-cycle completion.
//   oResult             : last completed product (low DATA_WIDTH bits).
//   oBusy               : sequencer is not idle.
module mul_share_sequencer
  import mul_share_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULSEQ_DEFAULT_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid0,
  input  logic [DATA_WIDTH-1:0] iA0,
  input  logic [DATA_WIDTH-1:0] iB0,
  output logic                  oReady0,
  output logic                  oDone0,
  input  logic                  iValid1,
  input  logic [DATA_WIDTH-1:0] iA1,
  input  logic [DATA_WIDTH-1:0] iB1,
  output logic                  oReady1,
  output logic                  oDone1,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oBusy
);

  logic [1:0]            state;
  logic                  last_grant;
  logic                  owner;
  logic                  accept0;
  logic                  accept1;
  logic                  start;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] product;
  logic                  core_last;

  // A requester is only blocked by the other one when that one is valid
  // and is owed the next turn, so the two readies are exclusive under
  // contention.
  always_comb begin
    oBusy   = (state != MULSEQ_IDLE);
    oReady0 = (state == MULSEQ_IDLE) && (!iValid1 || last_grant);
    oReady1 = (state == MULSEQ_IDLE) && (!iValid0 || !last_grant);
    accept0 = iValid0 && oReady0;
    accept1 = iValid1 && oReady1;
    start   = accept0 || accept1;
    op_a    = accept1 ? iA1 : iA0;
    op_b    = accept1 ? iB1 : iB0;
  end

  mul_shift_add_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (start),
    .iA      (op_a),
    .iB      (op_b),
    .oProduct(product),
    .oLast   (core_last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= MULSEQ_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      oResult    <= '0;
      oDone0     <= 1'b0;
      oDone1     <= 1'b0;
    end else begin
      case (state)
        MULSEQ_IDLE: begin
          if (start) begin
            state      <= MULSEQ_RUN;
            owner      <= accept1;
            last_grant <= accept1;
          end
        end
        MULSEQ_RUN: begin
          if (core_last) begin
            state   <= MULSEQ_DONE;
            oResult <= product;
            oDone0  <= !owner;
            oDone1  <= owner;
          end
        end
        MULSEQ_DONE: begin
          state  <= MULSEQ_IDLE;
          oDone0 <= 1'b0;
          oDone1 <= 1'b0;
        end
        default: begin
          state  <= MULSEQ_IDLE;
          oDone0 <= 1'b0;
          oDone1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_sequencer.sv
// Self-checking bench for mul_share_sequencer: directed scenarios plus
// randomized transactions against a behavioural arbitration/product model.
module tb_mul_share_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         Reset;
  logic         iValid0, iValid1;
  logic [W-1:0] iA0, iB0, iA1, iB1;
  logic         oReady0, oReady1, oDone0, oDone1, oBusy;
  logic [W-1:0] oResult;

  int n_vec = 0;
  int n_err = 0;
  logic m_last = 1'b1;  // model: requester granted most recently

  always #5 clk = ~clk;

  mul_share_sequencer #(
    .DATA_WIDTH(W)
  ) dut (
    .Clock  (clk),
    .Reset  (Reset),
    .iValid0(iValid0),
    .iA0    (iA0),
    .iB0    (iB0),
    .oReady0(oReady0),
    .oDone0 (oDone0),
    .iValid1(iValid1),
    .iA1    (iA1),
    .iB1    (iB1),
    .oReady1(oReady1),
    .oDone1 (oDone1),
    .oResult(oResult),
    .oBusy  (oBusy)
  );

  // Reference model helpers.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[W-1:0];
  endfunction

  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return (last == 1'b1) ? 1'b0 : 1'b1;
    return v1 && !v0;
  endfunction

  // {ready0, ready1, busy during run, done0, done1, done still high next cycle, busy after}
  function automatic logic [6:0] exp_flags(input logic v0, input logic v1, input logic last);
    logic w;
    w = pick(v0, v1, last);
    return {(!v1 || last), (!v0 || !last), 1'b1, !w, w, 1'b0, 1'b0};
  endfunction

  // Drives one request from just after a negedge and observes it to completion.
  task automatic issue(input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic keep1, input logic scramble,
                       output logic [6:0] flags, output int lat, output logic [W-1:0] res);
    logic r0, r1, brun, d0, d1, extra, bafter;
    iValid0 = v0; iValid1 = v1; iA0 = a0; iB0 = b0; iA1 = a1; iB1 = b1;
    #1;
    r0 = oReady0; r1 = oReady1;
    @(negedge clk);
    iValid0 = 1'b0;
    iValid1 = v1 && keep1;
    if (scramble) begin
      iA0 = '1; iB0 = '1; iA1 = '1; iB1 = '1;
    end
    #1;
    brun = oBusy;
    lat = -1; d0 = 1'b0; d1 = 1'b0; res = '0; extra = 1'b1; bafter = 1'b1;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (oDone0 || oDone1) begin
        lat = k; d0 = oDone0; d1 = oDone1; res = oResult;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      extra = oDone0 || oDone1;
      bafter = oBusy;
    end
    flags = {r0, r1, brun, d0, d1, extra, bafter};
  endtask

  task automatic test_reset();
    Reset = 1'b1; iValid0 = 1'b0; iValid1 = 1'b0;
    iA0 = '0; iB0 = '0; iA1 = '0; iB1 = '0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    m_last = 1'b1;
    #1;
    n_vec++;
    if ({oReady0, oReady1, oBusy, oDone0, oDone1} !== 5'b11000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want %b", {oReady0, oReady1, oBusy, oDone0, oDone1}, 5'b11000);
    end
    n_vec++;
    if (oResult !== '0) begin
      n_err++;
      $display("FAIL reset_result: got %h want %h", oResult, {W{1'b0}});
    end
  endtask

  task automatic test_contention();
    logic [6:0] f, ef;
    int lat;
    logic [W-1:0] res, er;
    logic [2:0] v0s, v1s, keeps;
    logic w;
    v0s = 3'b101; v1s = 3'b111; keeps = 3'b001;
    for (int r = 0; r < 3; r++) begin
      ef = exp_flags(v0s[r], v1s[r], m_last);
      w  = pick(v0s[r], v1s[r], m_last);
      er = w ? ref_mul(16'd7, 16'd9) : ref_mul(16'h00FF, 16'h0101);
      issue(v0s[r], v1s[r], 16'h00FF, 16'h0101, 16'd7, 16'd9, keeps[r], 1'b0, f, lat, res);
      m_last = w;
      n_vec++;
      if (f !== ef) begin
        n_err++;
        $display("FAIL contention_flags[%0d]: got %b want %b", r, f, ef);
      end
      n_vec++;
      if (res !== er) begin
        n_err++;
        $display("FAIL contention_result[%0d]: got %h want %h", r, res, er);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] f;
    int lat;
    logic [W-1:0] res;
    issue(1'b1, 1'b0, 16'd3, 16'd5, '0, '0, 1'b0, 1'b0, f, lat, res);
    n_vec++;
    if (f !== exp_flags(1'b1, 1'b0, m_last)) begin
      n_err++;
      $display("FAIL single_flags: got %b want %b", f, exp_flags(1'b1, 1'b0, m_last));
    end
    m_last = 1'b0;
    n_vec++;
    if (lat !== W) begin
      n_err++;
      $display("FAIL single_latency: got %0d want %0d", lat, W);
    end
    n_vec++;
    if (res !== 16'd15) begin
      n_err++;
      $display("FAIL single_result: got %h want %h", res, 16'd15);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [6:0] f;
    int lat;
    logic [W-1:0] res;
    ta = '{16'h1234, 16'hFFFF, 16'h0000};
    tb = '{16'h0100, 16'hFFFF, 16'hABCD};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, ta[i], tb[i], '0, '0, 1'b0, 1'b0, f, lat, res);
      m_last = 1'b0;
      n_vec++;
      if (lat !== W) begin
        n_err++;
        $display("FAIL overflow_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      n_vec++;
      if (res !== ref_mul(ta[i], tb[i])) begin
        n_err++;
        $display("FAIL overflow_result[%0d]: got %h want %h", i, res, ref_mul(ta[i], tb[i]));
      end
    end
  endtask

  task automatic test_operand_change();
    logic [6:0] f;
    int lat;
    logic [W-1:0] res;
    issue(1'b0, 1'b1, '0, '0, 16'd6, 16'd7, 1'b0, 1'b1, f, lat, res);
    n_vec++;
    if (f !== exp_flags(1'b0, 1'b1, m_last)) begin
      n_err++;
      $display("FAIL opchange_flags: got %b want %b", f, exp_flags(1'b0, 1'b1, m_last));
    end
    m_last = 1'b1;
    n_vec++;
    if (res !== 16'd42) begin
      n_err++;
      $display("FAIL opchange_result: got %h want %h", res, 16'd42);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    iValid1 = 1'b1; iA1 = 16'd300; iB1 = 16'd11;
    @(negedge clk);
    iValid1 = 1'b0;
    repeat (7) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    m_last = 1'b1;
    #1;
    n_vec++;
    if ({oReady0, oReady1, oBusy, oDone0, oDone1} !== 5'b11000) begin
      n_err++;
      $display("FAIL abort_flags: got %b want %b", {oReady0, oReady1, oBusy, oDone0, oDone1}, 5'b11000);
    end
    n_vec++;
    if (oResult !== '0) begin
      n_err++;
      $display("FAIL abort_result: got %h want %h", oResult, {W{1'b0}});
    end
    dones = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (oDone0 || oDone1 || oBusy) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", dones);
    end
  endtask

  task automatic test_valid_drop();
    int d0s, d1s;
    logic [W-1:0] res;
    iValid1 = 1'b1; iA1 = 16'd25; iB1 = 16'd40;
    @(negedge clk);
    iValid1 = 1'b0; iValid0 = 1'b1; iA0 = 16'd9; iB0 = 16'd9;
    #1;
    n_vec++;
    if (oReady0 !== 1'b0) begin
      n_err++;
      $display("FAIL drop_ready0_busy: got %b want 0", oReady0);
    end
    repeat (3) @(negedge clk);
    iValid0 = 1'b0;
    m_last = 1'b1;
    d0s = 0; d1s = 0; res = '0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (oDone0) d0s++;
      if (oDone1) begin
        d1s++;
        res = oResult;
      end
    end
    n_vec++;
    if ({d0s, d1s} !== {32'd0, 32'd1}) begin
      n_err++;
      $display("FAIL drop_dones: got d0=%0d d1=%0d want d0=0 d1=1", d0s, d1s);
    end
    n_vec++;
    if (res !== ref_mul(16'd25, 16'd40)) begin
      n_err++;
      $display("FAIL drop_result: got %h want %h", res, ref_mul(16'd25, 16'd40));
    end
  endtask

  task automatic test_random();
    logic [6:0] f, ef;
    int lat;
    logic [W-1:0] res, er, a0, b0, a1, b1;
    logic v0, v1, w, scr;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      scr = 1'($urandom_range(0, 1));
      ef = exp_flags(v0, v1, m_last);
      w  = pick(v0, v1, m_last);
      er = w ? ref_mul(a1, b1) : ref_mul(a0, b0);
      issue(v0, v1, a0, b0, a1, b1, 1'b0, scr, f, lat, res);
      m_last = w;
      n_vec++;
      if (f !== ef) begin
        n_err++;
        $display("FAIL random_flags[%0d]: got %b want %b", i, f, ef);
      end
      n_vec++;
      if (lat !== W) begin
        n_err++;
        $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      n_vec++;
      if (res !== er) begin
        n_err++;
        $display("FAIL random_result[%0d]: got %h want %h", i, res, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_overflow();
    test_operand_change();
    test_reset_abort();
    test_valid_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
